// File: rtl/yaw_integrator_p.sv
// Gyro yaw integrator: offset calibration over 2^CAL_LOG2 samples, then a
// 3-stage pipeline (capture/compensate -> scale -> integrate) into a wrapping
// heading, with IR guard-rail nudges and a heading preset.
module yaw_integrator_p #(
   parameter int                   RATE_W      = 16,
   parameter int                   FRAC_W      = 3,
   parameter int                   CAL_LOG2    = 11,
   parameter int                   INT_W       = 27,
   parameter int                   HEAD_W      = 12,
   parameter int unsigned          SCALE_NUM   = 31,
   parameter logic [INT_W-1:0]     FUSION_STEP = 'h3000,
   parameter int                   DEADBAND    = 0,
   parameter logic [RATE_W-1:0]    CAL_LIMIT   = 16'h4000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              strt_cal,
   input  logic              vld,
   input  logic [RATE_W-1:0] yaw_rt,
   input  logic              lftIR,
   input  logic              rghtIR,
   input  logic              moving,
   input  logic              hdg_ld,
   input  logic [HEAD_W-1:0] hdg_ld_val,
   output logic              cal_done,
   output logic              cal_valid,
   output logic              cal_err,
   output logic              rdy,
   output logic [HEAD_W-1:0] heading
);

   localparam int CW    = RATE_W + FRAC_W;   // compensated rate width
   localparam int ACC_W = RATE_W + CAL_LOG2; // calibration accumulator width
   localparam int PW    = CW + 7;            // product width (comp x 7-bit signed gain)
   localparam logic [CAL_LOG2:0] CAL_N   = {1'b1, {CAL_LOG2{1'b0}}};
   localparam logic [CAL_LOG2:0] CNT_ONE = {{CAL_LOG2{1'b0}}, 1'b1};
   localparam logic signed [6:0] SCL     = {1'b0, SCALE_NUM[5:0]};
   localparam logic [CW:0]       DB      = DEADBAND[CW:0];

   typedef enum logic [1:0] {IDLE, CAL, RUN} state_t;

   state_t                  state_q, state_d;
   logic [2:0]              vld_pipe_q;
   logic [RATE_W-1:0]       raw_q;
   logic signed [CW-1:0]    comp_q, comp_d;
   logic signed [PW-1:0]    scaled_q, scaled_d;
   logic [ACC_W-1:0]        cal_acc_q;
   logic [CAL_LOG2:0]       cal_cnt_q;
   logic [CW-1:0]           offset_q;
   logic [INT_W-1:0]        yaw_int_q;

   logic                    clr_int;
   logic                    cal_full, cal_bad;
   logic [RATE_W:0]         raw_x, abs_raw;
   logic [CW-1:0]           comp_raw;
   logic [CW:0]             comp_x, abs_comp;
   logic signed [PW-1:0]    prod;
   logic [INT_W-1:0]        fusion, scaled_ext;
   logic                    unused_acc;

   // Low accumulator bits below the offset's fraction point are deliberately dropped.
   assign unused_acc = ^cal_acc_q;

   assign raw_x    = {raw_q[RATE_W-1], raw_q};
   assign abs_raw  = raw_x[RATE_W] ? -raw_x : raw_x;
   assign cal_full = (cal_cnt_q == CAL_N);
   assign cal_bad  = vld_pipe_q[0] && (abs_raw > {1'b0, CAL_LIMIT});

   assign comp_raw = {yaw_rt, {FRAC_W{1'b0}}} - offset_q;
   assign comp_x   = {comp_raw[CW-1], comp_raw};
   assign abs_comp = comp_x[CW] ? -comp_x : comp_x;
   assign comp_d   = (state_q == RUN && abs_comp <= DB) ? '0 : $signed(comp_raw);

   // Gain is SCALE_NUM/32; arithmetic shift floors toward -inf.
   assign prod     = comp_q * SCL;
   assign scaled_d = prod >>> 5;

   assign scaled_ext = {{(INT_W-PW){scaled_q[PW-1]}}, scaled_q};
   assign fusion     = ( lftIR && !rghtIR) ?  FUSION_STEP :
                       (!lftIR &&  rghtIR) ? -FUSION_STEP : '0;

   assign cal_valid = (state_q == RUN);
   assign rdy       = vld_pipe_q[2];
   assign heading   = yaw_int_q[INT_W-1 -: HEAD_W];

   // Next-state logic; clr_int flags edges that zero the integrator.
   always_comb begin
      state_d  = state_q;
      cal_done = 1'b0;
      cal_err  = 1'b0;
      clr_int  = 1'b0;
      case (state_q)
         IDLE: if (strt_cal) begin
            state_d = CAL;
            clr_int = 1'b1;
         end
         CAL: begin
            if (strt_cal) begin
               clr_int = 1'b1;
            end else if (cal_full) begin
               cal_done = 1'b1;
               clr_int  = 1'b1;
               state_d  = RUN;
            end else if (cal_bad) begin
               cal_err = 1'b1;
               state_d = IDLE;
            end
         end
         RUN: if (strt_cal) begin
            state_d = CAL;
            clr_int = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register and sample pipeline; valid bits shift in lock-step with data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         vld_pipe_q <= '0;
         raw_q      <= '0;
         comp_q     <= '0;
         scaled_q   <= '0;
      end else begin
         state_q    <= state_d;
         vld_pipe_q <= {vld_pipe_q[1:0], vld};
         raw_q      <= yaw_rt;
         comp_q     <= comp_d;
         scaled_q   <= scaled_d;
      end
   end

   // Calibration accumulator, sample count and latched offset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cal_acc_q <= '0;
         cal_cnt_q <= '0;
         offset_q  <= '0;
      end else begin
         if (strt_cal) begin
            cal_acc_q <= '0;
            cal_cnt_q <= '0;
         end else if (state_q == CAL && vld_pipe_q[0] && !cal_bad && !cal_full) begin
            cal_acc_q <= cal_acc_q + {{CAL_LOG2{raw_q[RATE_W-1]}}, raw_q};
            cal_cnt_q <= cal_cnt_q + CNT_ONE;
         end
         if (cal_done)
            offset_q <= cal_acc_q[RATE_W+CAL_LOG2-1 : CAL_LOG2-FRAC_W];
      end
   end

   // Integrator: clear beats preset beats accumulate; wraps two's-complement.
   always_ff @(posedge clk) begin
      if (rst)
         yaw_int_q <= '0;
      else if (clr_int)
         yaw_int_q <= '0;
      else if (hdg_ld && state_q != CAL)
         yaw_int_q <= {hdg_ld_val, {(INT_W-HEAD_W){1'b0}}};
      else if (state_q == RUN && moving && vld_pipe_q[1])
         yaw_int_q <= yaw_int_q + scaled_ext + fusion;
   end

endmodule

// File: tb/tb_yaw_integrator_p.sv
// Bench for yaw_integrator_p (CAL_LOG2=3): table of RUN samples with hand-derived
// headings, a scoreboard checking heading/latency on each rdy, plus calibration,
// abort, preset and wrap sequences.
module tb_yaw_integrator_p;

   logic        clk = 1'b0;
   logic        rst, strt_cal, vld, lftIR, rghtIR, moving, hdg_ld;
   logic [15:0] yaw_rt;
   logic [11:0] hdg_ld_val;
   logic        cal_done, cal_valid, cal_err, rdy;
   logic [11:0] heading;

   yaw_integrator_p #(.CAL_LOG2(3)) dut (
      .clk(clk), .rst(rst), .strt_cal(strt_cal), .vld(vld), .yaw_rt(yaw_rt),
      .lftIR(lftIR), .rghtIR(rghtIR), .moving(moving), .hdg_ld(hdg_ld),
      .hdg_ld_val(hdg_ld_val), .cal_done(cal_done), .cal_valid(cal_valid),
      .cal_err(cal_err), .rdy(rdy), .heading(heading)
   );

   always #5 clk = ~clk;

   int errors = 0, checks = 0, cyc = 0, n_done = 0, n_err = 0;

   typedef struct { int cyc; logic [11:0] hdg; } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   typedef struct { bit ld; logic [15:0] val; bit lft; bit rght; bit mov; logic [11:0] hdg; } vec_t;

   // RUN samples starting from yaw_int=0, offset=128.
   vec_t tbl[25] = '{
      '{0, 16'd16,   0, 0, 1, 12'h000}, '{0, 16'd16,   0, 0, 1, 12'h000},
      '{0, 16'd16,   0, 0, 1, 12'h000},
      '{0, 16'd1040, 0, 0, 1, 12'h000}, '{0, 16'd1040, 0, 0, 1, 12'h000},
      '{0, 16'd1040, 0, 0, 1, 12'h000}, '{0, 16'd1040, 0, 0, 1, 12'h000},
      '{0, 16'd1040, 0, 0, 1, 12'h001},
      '{0, 16'd1040, 0, 0, 0, 12'h001}, '{0, 16'd1040, 0, 0, 0, 12'h001},
      '{1, 16'h0000, 0, 0, 0, 12'h000},
      '{0, 16'd16,   1, 0, 1, 12'h000}, '{0, 16'd16,   1, 0, 1, 12'h000},
      '{0, 16'd16,   1, 0, 1, 12'h001}, '{0, 16'd16,   1, 0, 1, 12'h001},
      '{0, 16'd16,   1, 0, 1, 12'h001}, '{0, 16'd16,   1, 0, 1, 12'h002},
      '{0, 16'd16,   1, 0, 1, 12'h002}, '{0, 16'd16,   1, 0, 1, 12'h003},
      '{0, 16'd16,   1, 1, 1, 12'h003}, '{0, 16'd16,   1, 1, 1, 12'h003},
      '{0, 16'd16,   0, 1, 1, 12'h002},
      '{0, 16'hFC18, 0, 0, 1, 12'h002}, '{0, 16'hFC18, 0, 0, 1, 12'h002},
      '{0, 16'hFC18, 0, 0, 1, 12'h001}
   };

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: count pulses, pop scoreboard on every rdy.
   always @(negedge clk) begin
      if (cal_done) n_done++;
      if (cal_err)  n_err++;
      if (rdy) begin
         if (sb.size() == 0) chk("rdy_spurious", 1, 0);
         else begin
            mon_e = sb.pop_front();
            chk("rdy_latency", cyc - mon_e.cyc, 3);
            chk("heading", {20'd0, heading}, {20'd0, mon_e.hdg});
         end
      end
   end

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         chk("drain_timeout", sb.size(), 0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic send(input logic [15:0] r, input bit l, input bit rr, input bit m,
                       input logic [11:0] h);
      @(negedge clk);
      yaw_rt = r; lftIR = l; rghtIR = rr; moving = m; vld = 1'b1;
      sb.push_back('{cyc, h});
      @(negedge clk);
      vld = 1'b0;
      drain();
   endtask

   task automatic pulse_strt();
      @(negedge clk); strt_cal = 1'b1;
      @(negedge clk); strt_cal = 1'b0;
   endtask

   task automatic load(input logic [11:0] v, input logic [11:0] exp, input string name);
      @(negedge clk); hdg_ld = 1'b1; hdg_ld_val = v;
      @(negedge clk); hdg_ld = 1'b0;
      chk(name, {20'd0, heading}, {20'd0, exp});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; strt_cal = 0; vld = 0; lftIR = 0; rghtIR = 0; moving = 0;
      hdg_ld = 0; yaw_rt = '0; hdg_ld_val = '0;
      repeat (3) @(negedge clk);
      chk("rst_heading",   heading,   0);
      chk("rst_rdy",       rdy,       0);
      chk("rst_cal_valid", cal_valid, 0);
      chk("rst_cal_done",  cal_done,  0);
      chk("rst_cal_err",   cal_err,   0);
      rst = 1'b0;

      // Reset in the middle of calibration discards the partial count.
      pulse_strt();
      for (int i = 0; i < 4; i++) send(16'd16, 0, 0, 0, 12'h000);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("midcal_rst_valid",   cal_valid, 0);
      chk("midcal_rst_heading", heading,   0);
      chk("midcal_rst_rdy",     rdy,       0);
      pulse_strt();
      for (int i = 0; i < 7; i++) send(16'd16, 0, 0, 0, 12'h000);
      chk("cal7_no_done", n_done,    0);
      chk("cal7_invalid", cal_valid, 0);
      send(16'd16, 0, 0, 0, 12'h000);
      chk("cal8_done_once", n_done,    1);
      chk("cal8_valid",     cal_valid, 1);

      // Table-driven RUN vectors.
      for (int i = 0; i < 25; i++) begin
         if (tbl[i].ld) load(tbl[i].val[11:0], tbl[i].hdg, "tbl_load");
         else           send(tbl[i].val, tbl[i].lft, tbl[i].rght, tbl[i].mov, tbl[i].hdg);
      end
      lftIR = 0; rghtIR = 0; moving = 0;

      // Restart from RUN, then abort calibration with an out-of-range sample.
      pulse_strt();
      chk("recal_valid_drop", cal_valid, 0);
      chk("recal_heading0",   heading,   0);
      send(16'h5000, 0, 0, 0, 12'h000);
      chk("cal_err_pulse", n_err,     1);
      chk("cal_err_idle",  cal_valid, 0);
      load(12'h123, 12'h123, "idle_load");

      // Recalibrate, preset 0x7FF and wrap the heading positive.
      pulse_strt();
      chk("recal2_heading0", heading, 0);
      for (int i = 0; i < 8; i++) send(16'd16, 0, 0, 0, 12'h000);
      chk("recal2_done",  n_done,    2);
      chk("recal2_valid", cal_valid, 1);
      load(12'h7FF, 12'h7FF, "run_load_7ff");
      for (int i = 0; i < 4; i++) send(16'd1040, 0, 0, 1, 12'h7FF);
      send(16'd1040, 0, 0, 1, 12'h800);

      // strt_cal and hdg_ld together: calibration wins, load dropped.
      @(negedge clk); strt_cal = 1'b1; hdg_ld = 1'b1; hdg_ld_val = 12'h555;
      @(negedge clk); strt_cal = 1'b0; hdg_ld = 1'b0;
      chk("strt_ld_heading", heading,   0);
      chk("strt_ld_valid",   cal_valid, 0);
      load(12'h321, 12'h000, "cal_load_ignored");

      drain();
      chk("sb_empty",    sb.size(), 0);
      chk("total_done",  n_done,    2);
      chk("total_err",   n_err,     1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
